// File: rtl/min_receive_fsm.sv
// Purpose: byte-stuffed framed receiver (AA AA AA | ID | LEN | payload | CRC32 | 55) with payload streaming and frame verdict.
// Latency: every output is registered; payload and verdict strobes appear one cycle after the triggering byte's i_valid.
// Backpressure: none; one byte per cycle is accepted whenever i_valid is high, and the receiver never stalls the source.
module min_receive_fsm #(
   parameter int MAX_PAYLOAD = 255
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic [5:0] o_id,
   output logic [7:0] o_len,
   output logic [7:0] o_pl_data,
   output logic       o_pl_valid,
   output logic       o_pl_last,
   output logic       o_frame_ok,
   output logic       o_frame_err,
   output logic [1:0] o_err_code,
   output logic       o_busy
);

   localparam logic [7:0]  SYNC_BYTE = 8'hAA;
   localparam logic [7:0]  STUF_BYTE = 8'h55;
   localparam logic [7:0]  EOF_BYTE  = 8'h55;
   localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
   localparam logic [7:0]  MAX_LEN   = 8'(MAX_PAYLOAD);

   localparam logic [1:0] ERR_CRC  = 2'd0;
   localparam logic [1:0] ERR_EOF  = 2'd1;
   localparam logic [1:0] ERR_LEN  = 2'd2;
   localparam logic [1:0] ERR_SYNC = 2'd3;

   typedef enum logic [3:0] {
      S_SEARCH,
      S_ID,
      S_LEN,
      S_PAYLOAD,
      S_CRC3,
      S_CRC2,
      S_CRC1,
      S_CRC0,
      S_EOF
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  stuff_cnt_q, stuff_cnt_d;
   logic [31:0] crc_q, crc_d;
   logic [31:0] rx_crc_q, rx_crc_d;
   logic [7:0]  pcnt_q, pcnt_d;

   logic [5:0]  id_d;
   logic [7:0]  len_d;
   logic [7:0]  pl_data_d;
   logic        pl_valid_d, pl_last_d;
   logic        frame_ok_d, frame_err_d;
   logic [1:0]  err_code_d;
   logic        busy_d;
   logic        in_frame;
   logic        pl_final;

   // Reflected CRC-32 advanced by one whole byte in a single cycle.
   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int k = 0; k < 8; k++) begin
         r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      end
      return r;
   endfunction

   assign in_frame = (state_q != S_SEARCH);
   assign pl_final = (({1'b0, pcnt_q} + 9'd1) == {1'b0, o_len});

   // Next-state and next-output logic: de-stuffing first, then one frame byte per accepted beat.
   always_comb begin
      state_d     = state_q;
      stuff_cnt_d = stuff_cnt_q;
      crc_d       = crc_q;
      rx_crc_d    = rx_crc_q;
      pcnt_d      = pcnt_q;
      id_d        = o_id;
      len_d       = o_len;
      pl_data_d   = o_pl_data;
      pl_valid_d  = 1'b0;
      pl_last_d   = 1'b0;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = 2'd0;

      if (i_valid) begin
         if (stuff_cnt_q == 2'd2) begin
            // Third byte after two 0xAA: header, stuff byte, or broken sync.
            stuff_cnt_d = 2'd0;
            if (i_data == SYNC_BYTE) begin
               state_d = S_ID;
               crc_d   = CRC_INIT;
               if (in_frame) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_SYNC;
               end
            end else if (i_data != STUF_BYTE) begin
               if (in_frame) begin
                  state_d     = S_SEARCH;
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_SYNC;
               end
            end
         end else begin
            stuff_cnt_d = (i_data == SYNC_BYTE) ? (stuff_cnt_q + 2'd1) : 2'd0;
            case (state_q)
               S_SEARCH: begin
                  state_d = S_SEARCH;
               end
               S_ID: begin
                  id_d    = i_data[5:0];
                  crc_d   = crc32_byte(crc_q, i_data);
                  state_d = S_LEN;
               end
               S_LEN: begin
                  len_d  = i_data;
                  crc_d  = crc32_byte(crc_q, i_data);
                  pcnt_d = 8'd0;
                  if (i_data > MAX_LEN) begin
                     state_d     = S_SEARCH;
                     frame_err_d = 1'b1;
                     err_code_d  = ERR_LEN;
                  end else if (i_data == 8'd0) begin
                     state_d = S_CRC3;
                  end else begin
                     state_d = S_PAYLOAD;
                  end
               end
               S_PAYLOAD: begin
                  crc_d      = crc32_byte(crc_q, i_data);
                  pl_data_d  = i_data;
                  pl_valid_d = 1'b1;
                  pl_last_d  = pl_final;
                  pcnt_d     = pcnt_q + 8'd1;
                  if (pl_final) begin
                     pcnt_d  = 8'd0;
                     state_d = S_CRC3;
                  end
               end
               S_CRC3: begin
                  rx_crc_d = {rx_crc_q[23:0], i_data};
                  state_d  = S_CRC2;
               end
               S_CRC2: begin
                  rx_crc_d = {rx_crc_q[23:0], i_data};
                  state_d  = S_CRC1;
               end
               S_CRC1: begin
                  rx_crc_d = {rx_crc_q[23:0], i_data};
                  state_d  = S_CRC0;
               end
               S_CRC0: begin
                  rx_crc_d = {rx_crc_q[23:0], i_data};
                  state_d  = S_EOF;
               end
               S_EOF: begin
                  // A bad terminator outranks a bad CRC.
                  state_d = S_SEARCH;
                  if (i_data != EOF_BYTE) begin
                     frame_err_d = 1'b1;
                     err_code_d  = ERR_EOF;
                  end else if (rx_crc_q != ~crc_q) begin
                     frame_err_d = 1'b1;
                     err_code_d  = ERR_CRC;
                  end else begin
                     frame_ok_d = 1'b1;
                  end
               end
               default: begin
                  state_d = S_SEARCH;
               end
            endcase
         end
      end

      busy_d = (state_d != S_SEARCH);
   end

   // State, counters, CRC and all registered outputs; reset drops any frame in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_SEARCH;
         stuff_cnt_q <= 2'd0;
         crc_q       <= CRC_INIT;
         rx_crc_q    <= 32'd0;
         pcnt_q      <= 8'd0;
         o_id        <= 6'd0;
         o_len       <= 8'd0;
         o_pl_data   <= 8'd0;
         o_pl_valid  <= 1'b0;
         o_pl_last   <= 1'b0;
         o_frame_ok  <= 1'b0;
         o_frame_err <= 1'b0;
         o_err_code  <= 2'd0;
         o_busy      <= 1'b0;
      end else begin
         state_q     <= state_d;
         stuff_cnt_q <= stuff_cnt_d;
         crc_q       <= crc_d;
         rx_crc_q    <= rx_crc_d;
         pcnt_q      <= pcnt_d;
         o_id        <= id_d;
         o_len       <= len_d;
         o_pl_data   <= pl_data_d;
         o_pl_valid  <= pl_valid_d;
         o_pl_last   <= pl_last_d;
         o_frame_ok  <= frame_ok_d;
         o_frame_err <= frame_err_d;
         o_err_code  <= err_code_d;
         o_busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_min_receive_fsm.sv
// Purpose: randomized and directed checks of min_receive_fsm against a frame-level reference model.
// Latency: expectations for a byte are compared one cycle after that byte is presented.
// Backpressure: none; the source paces bytes with optional idle gaps.
module tb_min_receive_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data = 8'd0;
   logic       valid = 1'b0;

   // Instance 0 uses the default MAX_PAYLOAD, instance 1 uses MAX_PAYLOAD = 4.
   logic [5:0] w_id [2];
   logic [7:0] w_len [2];
   logic [7:0] w_pld [2];
   logic       w_plv [2];
   logic       w_pll [2];
   logic       w_ok [2];
   logic       w_err [2];
   logic [1:0] w_code [2];
   logic       w_busy [2];

   always #5 clk = ~clk;

   min_receive_fsm u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
      .o_id(w_id[0]), .o_len(w_len[0]), .o_pl_data(w_pld[0]), .o_pl_valid(w_plv[0]),
      .o_pl_last(w_pll[0]), .o_frame_ok(w_ok[0]), .o_frame_err(w_err[0]),
      .o_err_code(w_code[0]), .o_busy(w_busy[0])
   );

   min_receive_fsm #(.MAX_PAYLOAD(4)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
      .o_id(w_id[1]), .o_len(w_len[1]), .o_pl_data(w_pld[1]), .o_pl_valid(w_plv[1]),
      .o_pl_last(w_pll[1]), .o_frame_ok(w_ok[1]), .o_frame_err(w_err[1]),
      .o_err_code(w_code[1]), .o_busy(w_busy[1])
   );

   typedef struct {
      logic [5:0] id;
      logic [7:0] len;
      logic       busy;
      logic       plv;
      logic [7:0] pld;
      logic       pll;
      logic       ok;
      logic       err;
      logic [1:0] code;
   } exp_t;

   exp_t pend [2];
   exp_t cur  [2];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model state: position inside the de-stuffed frame, not a state machine.
   int          run [2];
   bit          in_frame [2];
   int          pos [2];
   int          flen [2];
   logic [7:0]  body [2][0:299];
   int          blen [2];
   logic [31:0] rxc [2];
   logic [31:0] tbl [0:255];

   // Monitor records for hand-computed checks.
   int         okc [2];
   int         errc [2];
   logic [1:0] lastcode [2];
   int         ok_cyc;
   int         eof_cyc;
   logic [7:0] pl_log [0:63];
   logic       pl_lst [0:63];
   int         pl_n;

   logic [7:0] pl_buf [0:255];
   int         srun;
   bit         gap_en;

   task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s inst%0d cyc %0d: got 0x%0h expected 0x%0h", nm, m, cyc, act, expv);
      end
   endtask

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
      end
   endtask

   function automatic logic [31:0] tcrc(input logic [31:0] c, input logic [7:0] b);
      return tbl[c[7:0] ^ b] ^ (c >> 8);
   endfunction

   function automatic logic [31:0] crc_body(input int m);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < blen[m]; i++) c = tcrc(c, body[m][i]);
      return ~c;
   endfunction

   task automatic clr_strobes(input int m);
      pend[m].plv  = 1'b0;
      pend[m].pll  = 1'b0;
      pend[m].ok   = 1'b0;
      pend[m].err  = 1'b0;
      pend[m].code = 2'd0;
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         run[m] = 0; in_frame[m] = 1'b0; pos[m] = 0; flen[m] = 0; blen[m] = 0; rxc[m] = 32'd0;
         clr_strobes(m);
         pend[m].id = 6'd0; pend[m].len = 8'd0; pend[m].busy = 1'b0; pend[m].pld = 8'd0;
      end
   endtask

   task automatic model_idle();
      for (int m = 0; m < 2; m++) clr_strobes(m);
   endtask

   task automatic model_byte(input logic [7:0] b);
      for (int m = 0; m < 2; m++) begin
         int maxp;
         maxp = (m == 0) ? 255 : 4;
         clr_strobes(m);
         if (run[m] == 2) begin
            run[m] = 0;
            if (b == 8'hAA) begin
               if (in_frame[m]) begin pend[m].err = 1'b1; pend[m].code = 2'd3; end
               in_frame[m] = 1'b1; pos[m] = 0; blen[m] = 0;
            end else if (b != 8'h55 && in_frame[m]) begin
               pend[m].err = 1'b1; pend[m].code = 2'd3; in_frame[m] = 1'b0;
            end
         end else begin
            run[m] = (b == 8'hAA) ? run[m] + 1 : 0;
            if (in_frame[m]) begin
               if (pos[m] == 0) begin
                  pend[m].id = b[5:0]; body[m][blen[m]] = b; blen[m]++; pos[m]++;
               end else if (pos[m] == 1) begin
                  pend[m].len = b; flen[m] = int'(b); body[m][blen[m]] = b; blen[m]++;
                  if (int'(b) > maxp) begin
                     pend[m].err = 1'b1; pend[m].code = 2'd2; in_frame[m] = 1'b0;
                  end else pos[m]++;
               end else if (pos[m] < 2 + flen[m]) begin
                  pend[m].plv = 1'b1; pend[m].pld = b; pend[m].pll = (pos[m] == 1 + flen[m]);
                  body[m][blen[m]] = b; blen[m]++; pos[m]++;
               end else if (pos[m] < 6 + flen[m]) begin
                  rxc[m] = {rxc[m][23:0], b}; pos[m]++;
               end else begin
                  if (b != 8'h55) begin pend[m].err = 1'b1; pend[m].code = 2'd1; end
                  else if (rxc[m] != crc_body(m)) begin pend[m].err = 1'b1; pend[m].code = 2'd0; end
                  else pend[m].ok = 1'b1;
                  in_frame[m] = 1'b0;
               end
            end
         end
         pend[m].busy = in_frame[m];
      end
   endtask

   // Compare process: DUT outputs one cycle after each presented beat against the model.
   always @(posedge clk) begin
      cyc++;
      cur[0] = pend[0];
      cur[1] = pend[1];
      #1;
      for (int m = 0; m < 2; m++) begin
         chk("busy", m, 32'(w_busy[m]), 32'(cur[m].busy));
         chk("id", m, 32'(w_id[m]), 32'(cur[m].id));
         chk("len", m, 32'(w_len[m]), 32'(cur[m].len));
         chk("pl_valid", m, 32'(w_plv[m]), 32'(cur[m].plv));
         chk("pl_last", m, 32'(w_pll[m]), 32'(cur[m].pll));
         chk("frame_ok", m, 32'(w_ok[m]), 32'(cur[m].ok));
         chk("frame_err", m, 32'(w_err[m]), 32'(cur[m].err));
         if (cur[m].plv) chk("pl_data", m, 32'(w_pld[m]), 32'(cur[m].pld));
         if (cur[m].err) chk("err_code", m, 32'(w_code[m]), 32'(cur[m].code));
         if (w_ok[m]) okc[m]++;
         if (w_err[m]) begin errc[m]++; lastcode[m] = w_code[m]; end
      end
      if (w_ok[0]) ok_cyc = cyc;
      if (w_plv[0] && pl_n < 64) begin
         pl_log[pl_n] = w_pld[0]; pl_lst[pl_n] = w_pll[0]; pl_n++;
      end
   end

   task automatic clear_mon();
      for (int m = 0; m < 2; m++) begin okc[m] = 0; errc[m] = 0; lastcode[m] = 2'd0; end
      pl_n = 0; ok_cyc = -1; eof_cyc = -2;
   endtask

   task automatic drive(input logic v, input logic [7:0] b);
      @(negedge clk);
      valid = v;
      data  = b;
      if (v) model_byte(b); else model_idle();
   endtask

   task automatic send(input logic [7:0] b);
      if (gap_en && $urandom_range(0, 3) == 0) drive(1'b0, 8'h00);
      drive(1'b1, b);
   endtask

   task automatic send_st(input logic [7:0] b);
      send(b);
      srun = (b == 8'hAA) ? srun + 1 : 0;
      if (srun == 2) begin send(8'h55); srun = 0; end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      valid = 1'b0;
      model_reset();
      idle(2);
      @(negedge clk);
      rst_n = 1'b1;
      model_idle();
   endtask

   // Sends ID, LEN, payload from pl_buf, CRC (xor-corrupted) and terminator, optionally with header.
   task automatic send_frame(input bit hdr, input logic [7:0] id, input int len,
                             input logic [31:0] crc_xor, input logic [7:0] eofb);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      c = tcrc(c, id);
      c = tcrc(c, 8'(len));
      for (int i = 0; i < len; i++) c = tcrc(c, pl_buf[i]);
      c = ~c ^ crc_xor;
      if (hdr) begin send(8'hAA); send(8'hAA); send(8'hAA); end
      srun = 0;
      send_st(id);
      send_st(8'(len));
      for (int i = 0; i < len; i++) send_st(pl_buf[i]);
      send_st(c[31:24]); send_st(c[23:16]); send_st(c[15:8]); send_st(c[7:0]);
      send(eofb);
      eof_cyc = cyc;
      srun = 0;
   endtask

   initial begin
      logic [7:0]  chk9 [0:8];
      logic [31:0] c;
      for (int i = 0; i < 256; i++) begin
         c = 32'(i);
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         tbl[i] = c;
      end
      model_reset();
      clear_mon();
      gap_en = 1'b1;

      // Model pin: CRC-32 of "123456789" is 0xCBF43926.
      chk9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < 9; i++) c = tcrc(c, chk9[i]);
      lit("crc_model_pin", ~c, 32'hCBF4_3926);

      idle(3);
      lit("reset_busy", 32'(w_busy[0]), 32'd0);
      lit("reset_frame_ok", 32'(w_ok[0]), 32'd0);
      do_reset();

      // Good frame.
      clear_mon();
      pl_buf[0] = 8'h12; pl_buf[1] = 8'h34;
      send_frame(1'b1, 8'h05, 2, 32'd0, 8'h55);
      idle(3);
      lit("good_ok_cnt", 32'(okc[0]), 32'd1);
      lit("good_err_cnt", 32'(errc[0]), 32'd0);
      lit("good_pl_cnt", 32'(pl_n), 32'd2);
      lit("good_pl0", 32'(pl_log[0]), 32'h12);
      lit("good_pl1", 32'(pl_log[1]), 32'h34);
      lit("good_last0", 32'(pl_lst[0]), 32'd0);
      lit("good_last1", 32'(pl_lst[1]), 32'd1);
      lit("good_id", 32'(w_id[0]), 32'd5);
      lit("good_len", 32'(w_len[0]), 32'd2);

      // Stuffed payload AA AA 07 goes on the wire as AA AA 55 07.
      clear_mon();
      pl_buf[0] = 8'hAA; pl_buf[1] = 8'hAA; pl_buf[2] = 8'h07;
      send_frame(1'b1, 8'h01, 3, 32'd0, 8'h55);
      idle(3);
      lit("stuff_ok_cnt", 32'(okc[0]), 32'd1);
      lit("stuff_pl_cnt", 32'(pl_n), 32'd3);
      lit("stuff_pl0", 32'(pl_log[0]), 32'hAA);
      lit("stuff_pl1", 32'(pl_log[1]), 32'hAA);
      lit("stuff_pl2", 32'(pl_log[2]), 32'h07);

      // Corrupt last CRC byte.
      clear_mon();
      pl_buf[0] = 8'h12; pl_buf[1] = 8'h34;
      send_frame(1'b1, 8'h05, 2, 32'h0000_0001, 8'h55);
      idle(3);
      lit("crc_err_cnt", 32'(errc[0]), 32'd1);
      lit("crc_err_code", 32'(lastcode[0]), 32'd0);
      lit("crc_ok_cnt", 32'(okc[0]), 32'd0);

      // Bad terminator.
      clear_mon();
      send_frame(1'b1, 8'h05, 2, 32'd0, 8'h56);
      idle(3);
      lit("eof_err_cnt", 32'(errc[0]), 32'd1);
      lit("eof_err_code", 32'(lastcode[0]), 32'd1);

      // Over-length on the MAX_PAYLOAD=4 instance; the default instance accepts it.
      clear_mon();
      for (int i = 0; i < 5; i++) pl_buf[i] = 8'(i + 1);
      send_frame(1'b1, 8'h09, 5, 32'd0, 8'h55);
      idle(3);
      lit("len_err_cnt", 32'(errc[1]), 32'd1);
      lit("len_err_code", 32'(lastcode[1]), 32'd2);
      lit("len_ok_cnt1", 32'(okc[1]), 32'd0);
      lit("len_ok_cnt0", 32'(okc[0]), 32'd1);

      // Resync: header inside a payload, then the rest of a new frame.
      clear_mon();
      srun = 0;
      send(8'hAA); send(8'hAA); send(8'hAA);
      send_st(8'h03); send_st(8'h06); send_st(8'h11); send_st(8'h22);
      send(8'hAA); send(8'hAA); send(8'hAA);
      pl_buf[0] = 8'h5A; pl_buf[1] = 8'h6B;
      send_frame(1'b0, 8'h04, 2, 32'd0, 8'h55);
      idle(3);
      lit("resync_err_cnt", 32'(errc[0]), 32'd1);
      lit("resync_err_code", 32'(lastcode[0]), 32'd3);
      lit("resync_ok_cnt", 32'(okc[0]), 32'd1);
      lit("resync_id", 32'(w_id[0]), 32'd4);

      // Reset in the middle of a payload.
      clear_mon();
      srun = 0;
      send(8'hAA); send(8'hAA); send(8'hAA);
      send_st(8'h07); send_st(8'h04); send_st(8'h10); send_st(8'h20);
      do_reset();
      lit("rst_id", 32'(w_id[0]), 32'd0);
      lit("rst_strobes", 32'(okc[0] + errc[0] + okc[1] + errc[1]), 32'd0);
      pl_buf[0] = 8'h12; pl_buf[1] = 8'h34;
      send_frame(1'b1, 8'h05, 2, 32'd0, 8'h55);
      idle(3);
      lit("rst_next_ok", 32'(okc[0]), 32'd1);

      // Back-to-back bytes.
      clear_mon();
      gap_en = 1'b0;
      send_frame(1'b1, 8'h05, 2, 32'd0, 8'h55);
      idle(3);
      lit("b2b_ok_cnt", 32'(okc[0]), 32'd1);
      lit("b2b_ok_cycle", 32'(ok_cyc - eof_cyc), 32'd1);

      // Randomized traffic, all checked cycle by cycle against the model.
      for (int f = 0; f < 150; f++) begin
         int kind, len, ng;
         logic [7:0] id, gb, eb;
         logic [31:0] cx;
         gap_en = ($urandom_range(0, 1) == 1);
         kind = $urandom_range(0, 9);
         len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
         id   = 8'($urandom);
         for (int i = 0; i < len; i++)
            pl_buf[i] = ($urandom_range(0, 2) == 0) ? 8'hAA : 8'($urandom);
         ng = $urandom_range(0, 2);
         for (int i = 0; i < ng; i++) begin
            gb = 8'($urandom);
            if (gb == 8'hAA) gb = 8'h00;
            send(gb);
         end
         cx = 32'd0;
         eb = 8'h55;
         if (kind == 0) cx = 32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3));
         if (kind == 1) begin
            eb = 8'($urandom);
            if (eb == 8'h55 || eb == 8'hAA) eb = 8'h56;
         end
         if (kind == 2) begin
            srun = 0;
            send(8'hAA); send(8'hAA); send(8'hAA);
            send_st(id);
            send(8'hAA); send(8'hAA); send(8'hAA);
            send_frame(1'b0, id, len, cx, eb);
         end else if (kind == 3) begin
            srun = 0;
            send(8'hAA); send(8'hAA); send(8'hAA);
            send_st(id);
            send_st(8'(len));
            do_reset();
         end else begin
            send_frame(1'b1, id, len, cx, eb);
         end
         idle($urandom_range(0, 2));
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/min_receive_fsm.md
MIN_RECEIVE_FSM -- requirements
Module: min_receive_fsm

Interface
REQ-001 Parameter MAX_PAYLOAD, default 255, is the largest accepted LEN value (1..255).
REQ-002 Port i_clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 Port i_rst_n  input  1  is the reset: asynchronous, active-low.
REQ-004 Port i_data  input  8  is the received byte from the UART receiver.
REQ-005 Port i_valid  input  1  strobes i_data for one byte; back-to-back assertion is one byte per cycle.
REQ-006 Port o_id  output  6  is the frame ID: bits [5:0] of the ID/control byte.
REQ-007 Port o_len  output  8  is the payload length of the current frame.
REQ-008 Port o_pl_data  output  8  is a payload byte, not yet CRC-checked.
REQ-009 Port o_pl_valid  output  1  is a one-cycle strobe qualifying o_pl_data.
REQ-010 Port o_pl_last  output  1  is high with o_pl_valid on the final payload byte.
REQ-011 Port o_frame_ok  output  1  is a one-cycle strobe: frame complete, CRC and EOF good.
REQ-012 Port o_frame_err  output  1  is a one-cycle strobe: frame aborted.
REQ-013 Port o_err_code  output  2  gives the abort reason, valid with o_frame_err: 0 = CRC, 1 = EOF, 2 = length, 3 = stuffing/resync.
REQ-014 Port o_busy  output  1  is high while a frame is in progress (states ID..EOF).

Function
REQ-015 Frame format: AA AA AA | ID | LEN | LEN payload bytes | CRC32 (4 bytes, MSB first) | 55.
REQ-016 Byte-stuffing counter: a 2-bit count of consecutive received 0xAA bytes, applied to every byte in every state.
REQ-017 Count==2 and byte==0xAA: header detected; go to ID; clear count and CRC; if o_busy was high, pulse o_frame_err with code 3 in the same cycle.
REQ-018 Count==2 and byte==0x55: byte is a stuff byte; discard it (no state, CRC or output effect); clear count.
REQ-019 Count==2 and any other byte: in SEARCH, stay in SEARCH; in a frame state, abort with code 3 and go to SEARCH.
REQ-020 States: SEARCH, ID, LEN, PAYLOAD, CRC3, CRC2, CRC1, CRC0, EOF.
REQ-021 Each state consumes one unstuffed byte and advances.
REQ-022 LEN==0 goes directly to CRC3.
REQ-023 PAYLOAD leaves for CRC3 after LEN bytes.
REQ-024 EOF always returns to SEARCH.
REQ-025 LEN > MAX_PAYLOAD: pulse o_frame_err with code 2, go to SEARCH, no payload output.
REQ-026 CRC algorithm: CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
REQ-027 CRC coverage: the ID, LEN and payload bytes; stuff bytes excluded.
REQ-028 CRC update is byte-parallel and completes in the cycle of the byte's i_valid.
REQ-029 At EOF, byte != 0x55 gives o_frame_err with code 1.
REQ-030 At EOF, byte == 0x55 with received CRC != computed CRC gives o_frame_err with code 0.
REQ-031 At EOF, byte == 0x55 with matching CRC gives o_frame_ok.
REQ-032 If both the EOF and CRC checks fail, code 1 is reported.
REQ-033 Latency: all outputs are registered; strobes appear exactly one cycle after the i_valid of the triggering byte.
REQ-034 o_id and o_len are updated after the ID and LEN bytes respectively and held until the next header.
REQ-035 At most one of o_frame_ok and o_frame_err is high in any cycle.
REQ-036 A CRC byte of 0xAA counts toward stuffing like any other byte.
REQ-037 The payload counter is 8 bits and cannot wrap, because LEN <= 255.

Reset
REQ-038 i_rst_n low forces immediately: state SEARCH, stuff count 0, CRC 0xFFFFFFFF, payload counter 0.
REQ-039 i_rst_n low forces all outputs to 0.
REQ-040 Reset mid-frame discards the frame; no o_frame_ok or o_frame_err is generated.
REQ-041 The first byte accepted after reset release is treated as SEARCH input.

Verification
REQ-042 Good frame: AA AA AA 05 02 12 34 <CRC> 55, CRC from the bench CRC model -> o_pl_valid on 12 then 34 (o_pl_last on 34), o_id=5, o_len=2, one o_frame_ok, no o_frame_err.
REQ-043 Stuffed payload: ID 01, LEN 3, payload AA AA 07 sent as AA AA 55 07 -> payload bytes AA, AA, 07 only; CRC over the unstuffed bytes; o_frame_ok.
REQ-044 Corrupt CRC: good frame with the last CRC byte XOR 0x01 -> o_frame_err with o_err_code=0; no o_frame_ok.
REQ-045 Bad EOF and over-length: EOF byte 0x56 -> code 1; with MAX_PAYLOAD=4, LEN=5 -> code 2 one cycle after the LEN byte, then SEARCH.
REQ-046 Resync: AA AA AA inside a payload -> o_frame_err with code 3; the following frame decodes with o_frame_ok.
REQ-047 Reset mid-frame: i_rst_n low during the payload -> outputs 0, no strobes; the next good frame gives o_frame_ok.
REQ-048 Back-to-back bytes: the REQ-042 frame sent with i_valid high every cycle -> o_frame_ok exactly one cycle after the 55 byte.
